// File: rtl/fib_pkg.sv
// Shared types and default sizes for the Fibonacci sequencer.
//   fib_state_e : controller FSM states
//   FIB_WIDTH   : default result width
//   FIB_IDX_W   : default width of the requested index
package fib_pkg;
  localparam int FIB_WIDTH = 16;
  localparam int FIB_IDX_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fib_state_e;
endpackage

// File: rtl/fib_step_dp.sv
// Combinational Fibonacci step datapath.
// Given a=F(k) and b=F(k+1), it produces the next pair:
//   dbl=1 : (F(k+2), F(k+3)) = (a+b, a+2b)
//   dbl=0 : (F(k+1), F(k+2)) = (b, a+b)
// Ports:
//   a, b            in  WIDTH  current term pair (wrapped)
//   ovf_a, ovf_b    in  1      sticky flags: the true term is >= 2^WIDTH
//   dbl             in  1      select the double step
//   a_nxt, b_nxt    out WIDTH  next term pair
//   ovf_a_nxt/ovf_b_nxt out 1  next sticky flags
module fib_step_dp #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ovf_a,
  input  logic             ovf_b,
  input  logic             dbl,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic             ovf_a_nxt,
  output logic             ovf_b_nxt
);
  logic [WIDTH:0] s1;   // a + b with carry
  logic [WIDTH:0] s2;   // (a + b) + b with carry

  assign s1 = {1'b0, a} + {1'b0, b};
  assign s2 = {1'b0, s1[WIDTH-1:0]} + {1'b0, b};

  // A flag propagates from any operand: once a term exceeds the width,
  // every later term built from it does too.
  always_comb begin
    if (dbl) begin
      a_nxt     = s1[WIDTH-1:0];
      ovf_a_nxt = s1[WIDTH] | ovf_a | ovf_b;
      b_nxt     = s2[WIDTH-1:0];
      ovf_b_nxt = s2[WIDTH] | s1[WIDTH] | ovf_a | ovf_b;
    end else begin
      a_nxt     = b;
      ovf_a_nxt = ovf_b;
      b_nxt     = s1[WIDTH-1:0];
      ovf_b_nxt = s1[WIDTH] | ovf_a | ovf_b;
    end
  end
endmodule

// File: rtl/fib_seq_ctrl.sv
// Request/response Fibonacci controller: accepts index n, returns F(n).
// Advances two terms per cycle through fib_step_dp, with one single step
// when an odd count remains. Latency from accept to resp_valid is
// ceil(n/2)+1 cycles.
// Ports:
//   clk, rst               clock; asynchronous active-high reset
//   req_valid/req_n        request in, req_ready high in IDLE
//   resp_valid/resp_data   result out (held until resp_ready), resp_ovf
//                          set when the true F(n) >= 2^WIDTH
//   resp_ready             consumer accepts the result
//   busy                   controller not IDLE
// Build option: define FIB_SAT_EN to saturate resp_data to all-ones on
// overflow; otherwise resp_data is F(n) mod 2^WIDTH.
module fib_seq_ctrl
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int IDX_W = FIB_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [IDX_W-1:0] req_n,
  output logic             req_ready,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_ovf,
  input  logic             resp_ready,
  output logic             busy
);
  fib_state_e state, state_nxt;

  logic [WIDTH-1:0] a, b, a_nxt, b_nxt;
  logic             ovf_a, ovf_b, ovf_a_nxt, ovf_b_nxt;
  logic [IDX_W-1:0] rem;
  logic             dbl;
  logic [WIDTH-1:0] res;

  // rem >= 2 without a wide compare; also keeps rem from going below zero.
  assign dbl = |rem[IDX_W-1:1];

  fib_step_dp #(.WIDTH(WIDTH)) u_dp (
    .a         (a),
    .b         (b),
    .ovf_a     (ovf_a),
    .ovf_b     (ovf_b),
    .dbl       (dbl),
    .a_nxt     (a_nxt),
    .b_nxt     (b_nxt),
    .ovf_a_nxt (ovf_a_nxt),
    .ovf_b_nxt (ovf_b_nxt)
  );

`ifdef FIB_SAT_EN
  assign res = ovf_a ? {WIDTH{1'b1}} : a;
`else
  assign res = a;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nxt = RUN;
      end
      RUN:  if (rem == '0) state_nxt = DONE;
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a         <= '0;
      b         <= '0;
      ovf_a     <= 1'b0;
      ovf_b     <= 1'b0;
      rem       <= '0;
      resp_data <= '0;
      resp_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          a     <= '0;
          b     <= {{(WIDTH-1){1'b0}}, 1'b1};
          ovf_a <= 1'b0;
          ovf_b <= 1'b0;
          rem   <= req_n;
        end
        RUN: begin
          if (rem == '0) begin
            resp_data <= res;
            resp_ovf  <= ovf_a;
          end else begin
            a     <= a_nxt;
            b     <= b_nxt;
            ovf_a <= ovf_a_nxt;
            ovf_b <= ovf_b_nxt;
            rem   <= dbl ? rem - IDX_W'(2) : '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
